// File: rtl/uart_cmd_if.sv
// Byte handshakes (uart rx in, uart tx out) plus the local register bus seen by the command parser.
interface uart_cmd_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output rx_data, rx_valid, tx_ready, rd_data,
    input  rx_ready, tx_data, tx_valid, wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready, rd_data,
    output rx_ready, tx_data, tx_valid, wr_en, wr_addr, wr_data, rd_en, rd_addr
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/ADDR/DATA/CHK frames from uart rx bytes, drives register
// write/read strobes and answers with a single byte on the uart tx handshake.
module uart_cmd_parser #(
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
  parameter logic [DATA_WIDTH-1:0] ACK_BYTE       = 8'h06,
  parameter logic [DATA_WIDTH-1:0] NAK_BYTE       = 8'h15,
  parameter int                    TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ena,
  uart_cmd_if.slave             bus,
  output logic [DATA_WIDTH-1:0] err_count
);
  localparam logic [DATA_WIDTH-1:0] CMD_WR = 8'h01;
  localparam logic [DATA_WIDTH-1:0] CMD_RD = 8'h02;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RD_WAIT, S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cmd_q, addr_q, data_q, chk_q;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_byte;
  logic                  tx_valid_q;
  logic [TW-1:0]         tmo_q;
  logic                  in_frame, rx_fire, tx_fire, frame_ok, tmo_hit;
  logic                  wr_en, rd_en, err_inc, ld_tx;

  assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                    (state_q == S_DATA) || (state_q == S_CHK);
  assign bus.rx_ready = ena && (in_frame || state_q == S_IDLE);
  assign rx_fire  = bus.rx_valid && bus.rx_ready;
  assign tx_fire  = bus.tx_valid && bus.tx_ready;
  assign frame_ok = (chk_q == (cmd_q ^ addr_q ^ data_q)) && (cmd_q == CMD_WR || cmd_q == CMD_RD);
  assign tmo_hit  = in_frame && ena && !rx_fire && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = data_q;
  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = addr_q;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_inc = 1'b0;
    ld_tx   = 1'b0;
    tx_byte = '0;
    case (state_q)
      S_IDLE:    if (rx_fire && bus.rx_data == SYNC_BYTE) state_d = S_CMD;
      S_CMD:     if (rx_fire) state_d = S_ADDR; else if (tmo_hit) begin state_d = S_IDLE; err_inc = 1'b1; end
      S_ADDR:    if (rx_fire) state_d = S_DATA; else if (tmo_hit) begin state_d = S_IDLE; err_inc = 1'b1; end
      S_DATA:    if (rx_fire) state_d = S_CHK;  else if (tmo_hit) begin state_d = S_IDLE; err_inc = 1'b1; end
      S_CHK:     if (rx_fire) state_d = S_EXEC; else if (tmo_hit) begin state_d = S_IDLE; err_inc = 1'b1; end
      // Strobes are gated by ena so a frozen EXEC still yields exactly one pulse.
      S_EXEC: if (ena) begin
        if (!frame_ok) begin
          err_inc = 1'b1; ld_tx = 1'b1; tx_byte = NAK_BYTE; state_d = S_RESP;
        end else if (cmd_q == CMD_WR) begin
          wr_en = 1'b1; ld_tx = 1'b1; tx_byte = ACK_BYTE; state_d = S_RESP;
        end else begin
          rd_en = 1'b1; state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: if (ena) begin ld_tx = 1'b1; tx_byte = bus.rd_data; state_d = S_RESP; end
      S_RESP:    if (tx_fire) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      chk_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tmo_q      <= '0;
      err_count  <= '0;
    end else begin
      state_q <= state_d;
      if (rx_fire) begin
        case (state_q)
          S_CMD:   cmd_q  <= bus.rx_data;
          S_ADDR:  addr_q <= bus.rx_data;
          S_DATA:  data_q <= bus.rx_data;
          S_CHK:   chk_q  <= bus.rx_data;
          default: ;
        endcase
      end
      // A pending response may complete even while the parser is frozen.
      if (ld_tx) begin
        tx_data_q  <= tx_byte;
        tx_valid_q <= 1'b1;
      end else if (tx_fire) begin
        tx_valid_q <= 1'b0;
      end
      if (ena) begin
        if (!in_frame || rx_fire) tmo_q <= '0;
        else                      tmo_q <= tmo_q + 1'b1;
      end
      if (err_inc && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: expected register accesses and tx bytes are
// queued as each frame is driven and matched when the DUT produces them.
module tb_uart_cmd_parser;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] err_count;
  logic [7:0] err_exp = 8'h00;
  logic [7:0] rd_mem = 8'h00;
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  int checks = 0;
  int passed = 0;

  uart_cmd_if #(.DATA_WIDTH(8)) bus();

  uart_cmd_parser #(.TIMEOUT_CYCLES(20000)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .bus(bus.slave), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Register file model: read data valid on the cycle after rd_en, junk otherwise.
  always @(posedge clk) bus.rd_data <= bus.rd_en ? rd_mem : 8'h5A;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) if (reset_n) begin
    if (bus.tx_valid && bus.tx_ready) begin
      check("tx_expected_pending", exp_tx.size() > 0, 1);
      if (exp_tx.size() > 0) check("tx_byte", bus.tx_data, exp_tx.pop_front());
    end
    if (bus.wr_en || bus.rd_en) check("wr_rd_exclusive", bus.wr_en && bus.rd_en, 0);
    if (bus.wr_en) begin
      check("wr_expected_pending", exp_wr.size() > 0, 1);
      if (exp_wr.size() > 0) check("wr_addr_data", {bus.wr_addr, bus.wr_data}, exp_wr.pop_front());
    end
    if (bus.rd_en) begin
      check("rd_expected_pending", exp_rd.size() > 0, 1);
      if (exp_rd.size() > 0) check("rd_addr", bus.rd_addr, exp_rd.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (bus.rx_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    if (!done) check("rx_accept_timeout", done, 1);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] chk);
    send_byte(8'hA5); send_byte(cmd); send_byte(addr); send_byte(data); send_byte(chk);
  endtask

  task automatic wait_tx_valid();
    for (int i = 0; i < 200 && !bus.tx_valid; i++) begin @(posedge clk); #1; end
    check("tx_valid_rise", bus.tx_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_tx.size() + exp_wr.size() + exp_rd.size()) != 0; i++) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", exp_tx.size() + exp_wr.size() + exp_rd.size(), 0);
  endtask

  initial begin
    bit stable;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    #1;
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data",  bus.tx_data, 0);
    check("rst_wr_en",    bus.wr_en, 0);
    check("rst_rd_en",    bus.rd_en, 0);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_err",      err_count, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1; ena = 1'b1;
    @(negedge clk) check("idle_rx_ready", bus.rx_ready, 1);
    @(posedge clk); #1;

    // 1: write, with wr_en on the cycle after CHK and ACK one cycle later
    exp_wr.push_back(16'h105C); exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'h10, 8'h5C, 8'h4D);
    check("wr_latency", bus.wr_en, 1);
    @(posedge clk); #1;
    check("wr_single_pulse", bus.wr_en, 0);
    check("ack_latency", bus.tx_valid, 1);
    drain();
    check("err_after_write", err_count, err_exp);

    // 2: read, tx carries rd_data two cycles after EXEC
    rd_mem = 8'hC3; exp_rd.push_back(8'h22); exp_tx.push_back(8'hC3);
    send_frame(8'h02, 8'h22, 8'h00, 8'h20);
    check("rd_latency", bus.rd_en, 1);
    @(posedge clk); #1;
    check("rd_wait_no_tx", bus.tx_valid, 0);
    @(posedge clk); #1;
    check("rd_resp_latency", bus.tx_valid, 1);
    drain();

    // 3: bad checksum, then unknown command with a good checksum
    exp_tx.push_back(8'h15);
    send_frame(8'h01, 8'h10, 8'h5C, 8'h00);
    drain(); err_exp++;
    check("err_bad_chk", err_count, err_exp);
    exp_tx.push_back(8'h15);
    send_frame(8'h07, 8'h10, 8'h5C, 8'h4B);
    drain(); err_exp++;
    check("err_bad_cmd", err_count, err_exp);

    // 4: garbage ahead of a frame is dropped silently
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    exp_wr.push_back(16'h2077); exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'h20, 8'h77, 8'h56);
    drain();
    check("err_after_garbage", err_count, err_exp);

    // 5: inter-byte timeout, not early, then recovery
    send_byte(8'hA5); send_byte(8'h01);
    repeat (19990) @(posedge clk);
    #1 check("no_early_timeout", err_count, err_exp);
    repeat (20) @(posedge clk);
    #1 err_exp++;
    check("err_timeout", err_count, err_exp);
    exp_wr.push_back(16'h3011); exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'h30, 8'h11, 8'h20);
    drain();

    // 6a: response held stable while tx_ready is low
    bus.tx_ready = 1'b0;
    exp_wr.push_back(16'h40AA); exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'h40, 8'hAA, 8'hEB);
    wait_tx_valid();
    stable = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'h06)) stable = 1'b0;
    end
    check("tx_hold_stable", stable, 1);
    @(posedge clk); #1 bus.tx_ready = 1'b1;
    drain();

    // 6b: ena low mid-frame freezes, frame resumes afterwards
    exp_wr.push_back(16'h500F); exp_tx.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h01);
    ena = 1'b0;
    repeat (50) @(negedge clk);
    check("ena_low_rx_ready", bus.rx_ready, 0);
    @(posedge clk); #1 ena = 1'b1;
    send_byte(8'h50); send_byte(8'h0F); send_byte(8'h5E);
    drain();
    check("err_after_ena", err_count, err_exp);

    // 6c: pending response completes with ena low and returns to IDLE
    bus.tx_ready = 1'b0;
    exp_wr.push_back(16'h6001); exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'h60, 8'h01, 8'h60);
    wait_tx_valid();
    ena = 1'b0; bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    check("ena_low_tx_done", bus.tx_valid, 0);
    ena = 1'b1;
    @(negedge clk) check("idle_after_ena_tx", bus.rx_ready, 1);
    drain();

    // 6d: reset mid-frame clears err_count at once and restarts parsing
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h33);
    reset_n = 1'b0;
    #1 check("rst_mid_frame_err", err_count, 0);
    err_exp = 8'h00;
    @(posedge clk); #1 reset_n = 1'b1;
    exp_wr.push_back(16'h7012); exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'h70, 8'h12, 8'h63);
    drain();
    check("err_after_reset", err_count, err_exp);

    // 6e: reset during response drops tx_valid asynchronously
    bus.tx_ready = 1'b0;
    exp_wr.push_back(16'h8034); exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'h80, 8'h34, 8'hB5);
    wait_tx_valid();
    reset_n = 1'b0;
    #1 check("rst_mid_resp_tx_valid", bus.tx_valid, 0);
    exp_tx.delete();
    @(posedge clk); #1 reset_n = 1'b1; bus.tx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
